fetch_byte_queue: RTL and testbench
===================================

// Module: fetch_byte_queue
// PURPOSE
//  Producer end of the decoder's instruction-byte window. Issues 8-byte-aligned fetch reads,
//  packs the returned words into a circular byte queue and drives the 15-byte `buffer` window.
//  Frees exactly `byte_incr` bytes when the decoder consumes. Sits between the Sysbus read path
//  and Decoder; redirect_valid comes from branch/reset-vector logic.
// PARAMETERS
//  DEPTH       32  queue capacity in bytes (power of 2, >= 24)
//  MAX_OUT     2   maximum outstanding fetch requests (1..3)
// PORTS
//  clk             in   1      clock, all state updates on rising edge
//  reset           in   1      synchronous, active-high
//  redirect_valid  in   1      flush queue and restart fetch at redirect_pc
//  redirect_pc     in   64     new fetch byte address, any alignment
//  req_valid       out  1      fetch request pending
//  req_addr        out  64     fetch address, always 8-byte aligned
//  req_ready       in   1      request accepted when req_valid&&req_ready
//  resp_valid      in   1      one in-order response per accepted request
//  resp_data       in   64     byte k of the word = resp_data[8k+7:8k] (little-endian)
//  buffer          out  120    window; byte i = buffer[i*8 +: 8], i=0 is oldest byte
//  window_valid    out  1      bytes_avail >= 15
//  bytes_avail     out  6      bytes in queue, 0..DEPTH
//  consume         in   1      decoder retires byte_incr bytes this cycle
//  byte_incr       in   4      bytes to free, 0..15
// BEHAVIOUR
//  Reset: state=IDLE, rd_ptr=wr_ptr=0, count=0, outstanding=0; req_valid=0, req_addr=0,
//   window_valid=0, bytes_avail=0, buffer=0.
//  FSM: IDLE --redirect--> DRAIN if outstanding (incl. a request accepted this cycle) > 0, else FETCH.
//   FETCH --redirect--> same rule. DRAIN: no requests issued; each response discarded and
//   outstanding decremented; at outstanding==0 -> FETCH. Redirect in DRAIN only reloads the PC.
//  Redirect (highest priority): count=0, rd_ptr=wr_ptr=0, fetch_pc={redirect_pc[63:3],3'b0},
//   skip=redirect_pc[2:0]. Fill and consume in the same cycle are ignored. req_valid=0 next cycle.
//  Request issue (FETCH only): req_valid=1 when outstanding<MAX_OUT and
//   count + 8*(outstanding+1) <= DEPTH. req_addr holds stable until accepted. On accept,
//   fetch_pc+=8 and outstanding++. A fetch_pc wrap from 2^64-8 to 0 is permitted.
//  Fill: resp_valid in FETCH writes bytes skip..7 at wr_ptr (mod DEPTH). count += 8-skip.
//   Then skip=0 and outstanding--. Space was reserved at issue, so no overflow is possible.
//  Consume: when consume && byte_incr <= count, rd_ptr += byte_incr (mod DEPTH), count -= byte_incr.
//   consume with byte_incr > count is a protocol error: ignore it and fire an assertion.
//   byte_incr=0 is a no-op.
//  Same-cycle fill+consume: count_next = count + fill_bytes - byte_incr.
//   Consume uses the pre-fill count.
//  Outputs are registered. Filled bytes appear in buffer/bytes_avail the cycle after resp_valid.
//   A consume is reflected the next cycle. Window byte i with i >= count reads 8'h00.
//  Simultaneous req accept and resp: outstanding is unchanged.
//  Reset mid-operation: all state returns to the reset values. Responses arriving later while in
//   IDLE with outstanding==0 are discarded.
// TESTING
//  T1 reset held 2 cycles, then idle -> req_valid=0, window_valid=0, bytes_avail=0, buffer=0.
//  T2 redirect 0x1000, reqs accepted, resp 0x0706050403020100 then 0x0F0E0D0C0B0A0908 ->
//     req_addr 0x1000,0x1008; bytes_avail=16, window_valid=1, byte0=0x00, byte14=0x0E.
//  T3 redirect 0x1003, resp 0x0706050403020100 -> req_addr=0x1000, bytes_avail=5,
//     byte0=0x03, byte4=0x07, byte5=0x00.
//  T4 count=16, consume byte_incr=3 in the same cycle as an 8-byte fill -> bytes_avail=21,
//     new byte0 = old byte3; repeat across rd_ptr 31->0 wrap, ordering intact.
//  T5 redirect 0x2000 with 2 outstanding -> state DRAIN, both stale responses dropped,
//     bytes_avail stays 0, next req_addr=0x2000.
//  T6 no consume, req_ready=1 -> issue stops at count+8*(out+1)>32; bytes_avail peaks at 32,
//     then consume 15 with byte_incr=15 -> bytes_avail=17, issue resumes.

Source files
------------

// File: rtl/fetch_byte_queue.sv
// rtl/fetch_byte_queue.sv - fetch request issue and circular instruction-byte queue
// Feeds the decoder a 15-byte window built from 8-byte aligned fetch responses.
module fetch_byte_queue #(
  parameter int DEPTH   = 32,
  parameter int MAX_OUT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          redirect_valid,
  input  logic [63:0]   redirect_pc,
  output logic          req_valid,
  output logic [63:0]   req_addr,
  input  logic          req_ready,
  input  logic          resp_valid,
  input  logic [63:0]   resp_data,
  output logic [119:0]  buffer,
  output logic          window_valid,
  output logic [5:0]    bytes_avail,
  input  logic          consume,
  input  logic [3:0]    byte_incr
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t             state, state_nx;
  logic [PTR_W-1:0]   rd_ptr, rd_ptr_nx, wr_ptr, wr_ptr_nx;
  logic [5:0]         count, count_nx;
  logic [1:0]         outstanding, out_nx;
  logic [63:0]        fetch_pc, fetch_pc_nx;
  logic [2:0]         skip, skip_nx;
  logic [7:0]         mem [DEPTH];
  logic [7:0]         mem_nx [DEPTH];
  logic               req_valid_nx;
  logic [119:0]       buffer_nx;
  logic               accept, resp_take, fill, cons_ok;
  logic [3:0]         fill_bytes;

  always_comb begin
    logic [PTR_W-1:0] off;
    logic [PTR_W-1:0] idx;
    logic [2:0]       sel;
    off = '0;
    idx = '0;
    sel = '0;

    accept     = req_valid && req_ready;
    // Responses with nothing outstanding (e.g. after a reset) are stale and dropped.
    resp_take  = resp_valid && (outstanding != 2'd0);
    fill       = resp_take && (state == FETCH) && !redirect_valid;
    fill_bytes = fill ? (4'd8 - {1'b0, skip}) : 4'd0;
    cons_ok    = consume && !redirect_valid && ({2'b00, byte_incr} <= count);
    out_nx     = outstanding + {1'b0, accept} - {1'b0, resp_take};

    state_nx    = state;
    fetch_pc_nx = accept ? fetch_pc + 64'd8 : fetch_pc;
    skip_nx     = fill ? 3'd0 : skip;
    wr_ptr_nx   = wr_ptr + PTR_W'(fill_bytes);
    rd_ptr_nx   = cons_ok ? rd_ptr + PTR_W'(byte_incr) : rd_ptr;
    // Consume is checked against the pre-fill count.
    count_nx    = count + {2'b00, fill_bytes} - (cons_ok ? {2'b00, byte_incr} : 6'd0);

    if (state == DRAIN && out_nx == 2'd0)
      state_nx = FETCH;

    if (redirect_valid) begin
      count_nx    = 6'd0;
      rd_ptr_nx   = '0;
      wr_ptr_nx   = '0;
      fetch_pc_nx = {redirect_pc[63:3], 3'b000};
      skip_nx     = redirect_pc[2:0];
      state_nx    = (out_nx != 2'd0) ? DRAIN : FETCH;
    end

    for (int j = 0; j < DEPTH; j++) begin
      off       = PTR_W'(j) - wr_ptr;
      sel       = off[2:0] + skip;
      mem_nx[j] = mem[j];
      if (fill && (int'(off) < int'(fill_bytes)))
        mem_nx[j] = resp_data[{sel, 3'b000} +: 8];
    end

    for (int i = 0; i < 15; i++) begin
      idx = rd_ptr_nx + PTR_W'(i);
      buffer_nx[i*8 +: 8] = (i < int'(count_nx)) ? mem_nx[idx] : 8'h00;
    end

    // Space for every outstanding response is reserved before the request goes out.
    req_valid_nx = (state_nx == FETCH) && !redirect_valid &&
                   (int'(out_nx) < MAX_OUT) &&
                   (int'(count_nx) + 8 * (int'(out_nx) + 1) <= DEPTH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= 6'd0;
      outstanding  <= 2'd0;
      fetch_pc     <= 64'd0;
      skip         <= 3'd0;
      req_valid    <= 1'b0;
      req_addr     <= 64'd0;
      buffer       <= '0;
      window_valid <= 1'b0;
    end else begin
      if (consume && !redirect_valid)
        assert ({2'b00, byte_incr} <= count);
      state        <= state_nx;
      rd_ptr       <= rd_ptr_nx;
      wr_ptr       <= wr_ptr_nx;
      count        <= count_nx;
      outstanding  <= out_nx;
      fetch_pc     <= fetch_pc_nx;
      skip         <= skip_nx;
      req_valid    <= req_valid_nx;
      req_addr     <= fetch_pc_nx;
      buffer       <= buffer_nx;
      window_valid <= (count_nx >= 6'd15);
    end
  end

  always_ff @(posedge clk) begin
    mem <= mem_nx;
  end

  assign bytes_avail = count;

endmodule

// File: tb/tb_fetch_byte_queue.sv
// tb/tb_fetch_byte_queue.sv - directed self-checking bench for fetch_byte_queue
// Response bytes equal the low byte of their fetch address, so window bytes track addresses.
module tb_fetch_byte_queue;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          redirect_valid = 1'b0;
  logic [63:0]   redirect_pc = 64'd0;
  logic          req_valid;
  logic [63:0]   req_addr;
  logic          req_ready = 1'b0;
  logic          resp_valid = 1'b0;
  logic [63:0]   resp_data = 64'd0;
  logic [119:0]  buffer;
  logic          window_valid;
  logic [5:0]    bytes_avail;
  logic          consume = 1'b0;
  logic [3:0]    byte_incr = 4'd0;

  int checks = 0;
  int failures = 0;

  fetch_byte_queue #(.DEPTH(32), .MAX_OUT(2)) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .buffer(buffer), .window_valid(window_valid), .bytes_avail(bytes_avail),
    .consume(consume), .byte_incr(byte_incr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          has_req;
    logic [63:0] addr;
    bit          cons;
    logic [3:0]  incr;
    logic [5:0]  avail;
    logic [7:0]  b0;
    logic [7:0]  b14;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] bufb(input int i);
    return buffer[i*8 +: 8];
  endfunction

  function automatic logic [63:0] mk_word(input logic [63:0] addr);
    logic [63:0] w;
    for (int k = 0; k < 8; k++) w[k*8 +: 8] = addr[7:0] + 8'(k);
    return w;
  endfunction

  task automatic redirect(input logic [63:0] pc);
    redirect_valid = 1'b1;
    redirect_pc = pc;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic accept_req(input logic [63:0] exp_addr, input string name);
    int n = 0;
    while (!req_valid && n < 20) begin
      tick();
      n++;
    end
    check({name, "_req_valid"}, {63'd0, req_valid}, 64'd1);
    check({name, "_req_addr"}, req_addr, exp_addr);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
  endtask

  task automatic send_resp(input logic [63:0] data);
    resp_valid = 1'b1;
    resp_data = data;
    tick();
    resp_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] q[$];
    logic [63:0] exp_addr;
    int n_acc;
    int peak;
    bit acc_now;

    vecs[0] = '{1'b1, 64'h3000, 1'b0, 4'd0,  6'd8,  8'h00, 8'h00};
    vecs[1] = '{1'b1, 64'h3008, 1'b0, 4'd0,  6'd16, 8'h00, 8'h0E};
    vecs[2] = '{1'b1, 64'h3010, 1'b1, 4'd3,  6'd21, 8'h03, 8'h11};
    vecs[3] = '{1'b1, 64'h3018, 1'b1, 4'd3,  6'd26, 8'h06, 8'h14};
    vecs[4] = '{1'b0, 64'h0,    1'b1, 4'd10, 6'd16, 8'h10, 8'h1E};
    vecs[5] = '{1'b1, 64'h3020, 1'b1, 4'd12, 6'd12, 8'h1C, 8'h00};
    vecs[6] = '{1'b1, 64'h3028, 1'b1, 4'd5,  6'd15, 8'h21, 8'h2F};
    vecs[7] = '{1'b1, 64'h3030, 1'b1, 4'd15, 6'd8,  8'h30, 8'h00};

    // T1 reset
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("t1_req_valid", {63'd0, req_valid}, 64'd0);
    check("t1_window_valid", {63'd0, window_valid}, 64'd0);
    check("t1_bytes_avail", {58'd0, bytes_avail}, 64'd0);
    check("t1_buffer_nonzero", {63'd0, |buffer}, 64'd0);
    check("t1_req_addr", req_addr, 64'd0);

    // T2 aligned redirect, two words
    redirect(64'h1000);
    check("t2_req_valid_after_redirect", {63'd0, req_valid}, 64'd0);
    accept_req(64'h1000, "t2_req0");
    accept_req(64'h1008, "t2_req1");
    send_resp(mk_word(64'h1000));
    send_resp(mk_word(64'h1008));
    check("t2_bytes_avail", {58'd0, bytes_avail}, 64'd16);
    check("t2_window_valid", {63'd0, window_valid}, 64'd1);
    check("t2_byte0", {56'd0, bufb(0)}, 64'h00);
    check("t2_byte14", {56'd0, bufb(14)}, 64'h0E);

    // T3 unaligned redirect skips leading bytes
    redirect(64'h1003);
    accept_req(64'h1000, "t3_req0");
    send_resp(mk_word(64'h1000));
    check("t3_bytes_avail", {58'd0, bytes_avail}, 64'd5);
    check("t3_byte0", {56'd0, bufb(0)}, 64'h03);
    check("t3_byte4", {56'd0, bufb(4)}, 64'h07);
    check("t3_byte5", {56'd0, bufb(5)}, 64'h00);
    check("t3_window_valid", {63'd0, window_valid}, 64'd0);

    // T4 table: fill and consume together, rd_ptr wraps 31->0
    redirect(64'h3000);
    for (int v = 0; v < 8; v++) begin
      if (vecs[v].has_req) accept_req(vecs[v].addr, $sformatf("t4_row%0d", v));
      resp_valid = vecs[v].has_req;
      resp_data  = mk_word(vecs[v].addr);
      consume    = vecs[v].cons;
      byte_incr  = vecs[v].incr;
      tick();
      resp_valid = 1'b0;
      consume    = 1'b0;
      byte_incr  = 4'd0;
      check($sformatf("t4_row%0d_avail", v), {58'd0, bytes_avail}, {58'd0, vecs[v].avail});
      check($sformatf("t4_row%0d_window_valid", v), {63'd0, window_valid},
            {63'd0, vecs[v].avail >= 6'd15});
      check($sformatf("t4_row%0d_byte0", v), {56'd0, bufb(0)}, {56'd0, vecs[v].b0});
      check($sformatf("t4_row%0d_byte14", v), {56'd0, bufb(14)}, {56'd0, vecs[v].b14});
    end

    // T5 redirect with two outstanding: drain stale responses
    accept_req(64'h3038, "t5_req0");
    accept_req(64'h3040, "t5_req1");
    redirect(64'h2000);
    check("t5_avail_after_redirect", {58'd0, bytes_avail}, 64'd0);
    check("t5_req_valid_after_redirect", {63'd0, req_valid}, 64'd0);
    tick();
    tick();
    tick();
    check("t5_no_issue_in_drain", {63'd0, req_valid}, 64'd0);
    send_resp(mk_word(64'h3038));
    check("t5_stale0_dropped", {58'd0, bytes_avail}, 64'd0);
    check("t5_still_draining", {63'd0, req_valid}, 64'd0);
    send_resp(mk_word(64'h3040));
    check("t5_stale1_dropped", {58'd0, bytes_avail}, 64'd0);
    accept_req(64'h2000, "t5_req_new");
    send_resp(mk_word(64'h2000));
    check("t5_new_avail", {58'd0, bytes_avail}, 64'd8);
    check("t5_new_byte0", {56'd0, bufb(0)}, 64'h00);

    // T6 fill to capacity with ready held high, then free 15 bytes
    redirect(64'h4000);
    req_ready = 1'b1;
    exp_addr = 64'h4000;
    n_acc = 0;
    peak = 0;
    for (int c = 0; c < 30; c++) begin
      if (int'(bytes_avail) > peak) peak = int'(bytes_avail);
      acc_now = req_valid;
      if (acc_now) begin
        check($sformatf("t6_req_addr%0d", n_acc), req_addr, exp_addr);
        exp_addr += 64'd8;
        n_acc++;
      end
      if (q.size() > 0) begin
        resp_valid = 1'b1;
        resp_data = mk_word(q.pop_front());
      end else begin
        resp_valid = 1'b0;
      end
      if (acc_now) q.push_back(req_addr);
      tick();
    end
    resp_valid = 1'b0;
    req_ready = 1'b0;
    if (int'(bytes_avail) > peak) peak = int'(bytes_avail);
    check("t6_accepted", 64'(n_acc), 64'd4);
    check("t6_peak", 64'(peak), 64'd32);
    check("t6_avail_full", {58'd0, bytes_avail}, 64'd32);
    check("t6_issue_stopped", {63'd0, req_valid}, 64'd0);
    consume = 1'b1;
    byte_incr = 4'd15;
    tick();
    consume = 1'b0;
    byte_incr = 4'd0;
    check("t6_avail_after_consume", {58'd0, bytes_avail}, 64'd17);
    check("t6_byte0", {56'd0, bufb(0)}, 64'h0F);
    check("t6_byte14", {56'd0, bufb(14)}, 64'h1D);
    check("t6_issue_resumed", {63'd0, req_valid}, 64'd1);
    check("t6_resume_addr", req_addr, 64'h4020);

    // Reset with a request outstanding; late response is discarded in IDLE
    accept_req(64'h4020, "rst_req");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_avail", {58'd0, bytes_avail}, 64'd0);
    check("rst_req_valid", {63'd0, req_valid}, 64'd0);
    check("rst_buffer_nonzero", {63'd0, |buffer}, 64'd0);
    send_resp(mk_word(64'h4020));
    check("rst_late_resp_dropped", {58'd0, bytes_avail}, 64'd0);
    check("rst_idle_no_issue", {63'd0, req_valid}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
